// File: rtl/fp_mult_accum.sv
// Streaming reduction stage: sums a group of fixed-point products and emits one narrowed result per group.
// Optional clamping of out-of-range sums is enabled by defining FP_MULT_ACCUM_SAT_EN.
module fp_mult_accum #(
    parameter int WIDTH      = 32,
    parameter int INT_WIDTH  = 1,
    parameter int FRAC_WIDTH = 31,
    parameter int GUARD      = 8,
    parameter int CNT_WIDTH  = 8,
    parameter int SIGNED     = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_sat,
    output logic [CNT_WIDTH-1:0] out_count,
    output logic                 o_dbg_state
);
    localparam int AW = WIDTH + GUARD;

    // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
    // a producer holds its data stable while valid is high and ready is low.
    typedef enum logic {ST_ACC = 1'b0, ST_HOLD = 1'b1} state_t;

    if (INT_WIDTH + FRAC_WIDTH != WIDTH) begin : g_fmt_check
        $error("fp_mult_accum: INT_WIDTH + FRAC_WIDTH must equal WIDTH");
    end

    state_t                 r_state;
    state_t                 w_state_next;
    logic [AW-1:0]          r_acc;
    logic [CNT_WIDTH-1:0]   r_count;
    logic [WIDTH-1:0]       r_out_data;
    logic                   r_out_sat;
    logic [CNT_WIDTH-1:0]   r_out_count;

    logic                   w_accept;
    logic [AW-1:0]          w_ext;
    logic [AW-1:0]          w_sum;
    logic [CNT_WIDTH-1:0]   w_count_inc;
    logic [WIDTH-1:0]       w_narrow;
    logic                   w_sat;

    assign w_accept    = in_valid & in_ready;
    assign w_ext       = (SIGNED != 0) ? {{GUARD{in_data[WIDTH-1]}}, in_data}
                                       : {{GUARD{1'b0}}, in_data};
    assign w_count_inc = (&r_count) ? r_count : r_count + CNT_WIDTH'(1);

`ifdef FP_MULT_ACCUM_SAT_EN
    logic [AW:0]      w_sum_full;
    logic             r_ovf;
    logic             r_ovf_neg;
    logic             w_add_ovf;
    logic             w_ovf_any;
    logic             w_ovf_neg;
    logic [GUARD:0]   w_top;
    logic             w_fits;
    logic             w_neg;

    assign w_sum_full = {1'b0, r_acc} + {1'b0, w_ext};
    assign w_sum      = w_sum_full[AW-1:0];
    assign w_add_ovf  = (SIGNED != 0)
                        ? ((r_acc[AW-1] == w_ext[AW-1]) && (w_sum[AW-1] != r_acc[AW-1]))
                        : w_sum_full[AW];
    assign w_ovf_any  = r_ovf | w_add_ovf;
    // Once the guard bits wrap, the sum's sign is meaningless; remember the direction it was heading.
    assign w_ovf_neg  = r_ovf ? r_ovf_neg : r_acc[AW-1];
    assign w_top      = w_sum[AW-1:WIDTH-1];
    assign w_fits     = (SIGNED != 0) ? ((&w_top) | ~(|w_top)) : ~(|w_sum[AW-1:WIDTH]);
    assign w_neg      = w_ovf_any ? w_ovf_neg : w_sum[AW-1];
    assign w_sat      = w_ovf_any | ~w_fits;

    always_comb begin
        w_narrow = w_sum[WIDTH-1:0];
        if (w_sat) begin
            if (SIGNED != 0) begin
                w_narrow = w_neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
            end else begin
                w_narrow = {WIDTH{1'b1}};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf     <= 1'b0;
            r_ovf_neg <= 1'b0;
        end else if (w_accept) begin
            r_ovf     <= in_last ? 1'b0 : w_ovf_any;
            r_ovf_neg <= in_last ? 1'b0 : w_ovf_neg;
        end
    end
`else
    assign w_sum    = r_acc + w_ext;
    assign w_narrow = w_sum[WIDTH-1:0];
    assign w_sat    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_ACC;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_ACC:  if (w_accept && in_last) w_state_next = ST_HOLD;
            ST_HOLD: if (out_ready)           w_state_next = ST_ACC;
            default: w_state_next = ST_ACC;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            ST_ACC:  in_ready  = 1'b1;
            ST_HOLD: out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc       <= '0;
            r_count     <= '0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
            r_out_count <= '0;
        end else if (w_accept) begin
            if (in_last) begin
                r_acc       <= '0;
                r_count     <= '0;
                r_out_data  <= w_narrow;
                r_out_sat   <= w_sat;
                r_out_count <= w_count_inc;
            end else begin
                r_acc   <= w_sum;
                r_count <= w_count_inc;
            end
        end
    end

    assign out_data    = r_out_data;
    assign out_sat     = r_out_sat;
    assign out_count   = r_out_count;
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_fp_mult_accum.sv
// Directed bench for fp_mult_accum: one signed and one unsigned instance, hand-computed expectations.
module tb_fp_mult_accum;
    logic        clk = 1'b0;
    logic        reset;

    logic        s_in_valid, s_in_last, s_in_ready, s_out_valid, s_out_ready, s_out_sat, s_dbg;
    logic [31:0] s_in_data, s_out_data;
    logic [7:0]  s_out_count;

    logic        u_in_valid, u_in_last, u_in_ready, u_out_valid, u_out_ready, u_out_sat, u_dbg;
    logic [31:0] u_in_data, u_out_data;
    logic [7:0]  u_out_count;

    int total = 0;
    int bad   = 0;

`ifdef FP_MULT_ACCUM_SAT_EN
    localparam logic [31:0] EXP_POS_OVF = 32'h7FFF_FFFF;
    localparam logic [31:0] EXP_NEG_OVF = 32'h8000_0000;
    localparam logic [31:0] EXP_GUARD   = 32'h7FFF_FFFF;
    localparam logic [31:0] EXP_U_OVF   = 32'hFFFF_FFFF;
    localparam logic        EXP_SAT     = 1'b1;
`else
    localparam logic [31:0] EXP_POS_OVF = 32'h8000_0000;
    localparam logic [31:0] EXP_NEG_OVF = 32'h0000_0000;
    localparam logic [31:0] EXP_GUARD   = 32'hFFFF_FED4;
    localparam logic [31:0] EXP_U_OVF   = 32'h0000_0001;
    localparam logic        EXP_SAT     = 1'b0;
`endif

    always #5 clk = ~clk;

    fp_mult_accum #(.SIGNED(1)) u_sgn (
        .clk(clk), .reset(reset),
        .in_valid(s_in_valid), .in_data(s_in_data), .in_last(s_in_last), .in_ready(s_in_ready),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .out_sat(s_out_sat), .out_count(s_out_count), .o_dbg_state(s_dbg)
    );

    fp_mult_accum #(.SIGNED(0)) u_uns (
        .clk(clk), .reset(reset),
        .in_valid(u_in_valid), .in_data(u_in_data), .in_last(u_in_last), .in_ready(u_in_ready),
        .out_valid(u_out_valid), .out_ready(u_out_ready), .out_data(u_out_data),
        .out_sat(u_out_sat), .out_count(u_out_count), .o_dbg_state(u_dbg)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic s_beat(input logic [31:0] d, input logic l);
        chk("s_in_ready_before_beat", 32'(s_in_ready), 32'd1);
        s_in_valid = 1'b1;
        s_in_data  = d;
        s_in_last  = l;
        tick();
        s_in_valid = 1'b0;
        s_in_last  = 1'b0;
    endtask

    task automatic u_beat(input logic [31:0] d, input logic l);
        chk("u_in_ready_before_beat", 32'(u_in_ready), 32'd1);
        u_in_valid = 1'b1;
        u_in_data  = d;
        u_in_last  = l;
        tick();
        u_in_valid = 1'b0;
        u_in_last  = 1'b0;
    endtask

    task automatic s_result(input string tag, input logic [31:0] d, input logic [7:0] c, input logic s);
        chk({tag, "_valid"}, 32'(s_out_valid), 32'd1);
        chk({tag, "_ready"}, 32'(s_in_ready), 32'd0);
        chk({tag, "_data"},  s_out_data, d);
        chk({tag, "_count"}, 32'(s_out_count), 32'(c));
        chk({tag, "_sat"},   32'(s_out_sat), 32'(s));
    endtask

    task automatic u_result(input string tag, input logic [31:0] d, input logic [7:0] c, input logic s);
        chk({tag, "_valid"}, 32'(u_out_valid), 32'd1);
        chk({tag, "_data"},  u_out_data, d);
        chk({tag, "_count"}, 32'(u_out_count), 32'(c));
        chk({tag, "_sat"},   32'(u_out_sat), 32'(s));
    endtask

    task automatic s_drain(input string tag);
        s_out_ready = 1'b1;
        tick();
        s_out_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(s_out_valid), 32'd0);
        chk({tag, "_ready_back"}, 32'(s_in_ready), 32'd1);
    endtask

    task automatic u_drain(input string tag);
        u_out_ready = 1'b1;
        tick();
        u_out_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(u_out_valid), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        s_in_valid = 1'b0; s_in_last = 1'b0; s_in_data = '0; s_out_ready = 1'b0;
        u_in_valid = 1'b0; u_in_last = 1'b0; u_in_data = '0; u_out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_in_ready",  32'(s_in_ready), 32'd1);
        chk("rst_out_valid", 32'(s_out_valid), 32'd0);
        chk("rst_out_data",  s_out_data, 32'd0);
        chk("rst_out_sat",   32'(s_out_sat), 32'd0);
        chk("rst_out_count", 32'(s_out_count), 32'd0);
        chk("rst_u_valid",   32'(u_out_valid), 32'd0);

        // Two-term sum with latency check
        s_beat(32'h2000_0000, 1'b0);
        chk("two_valid_early", 32'(s_out_valid), 32'd0);
        s_beat(32'h1000_0000, 1'b1);
        s_result("two", 32'h3000_0000, 8'd2, 1'b0);
        s_drain("two");

        // Positive overflow of the output format
        s_beat(32'h4000_0000, 1'b0);
        s_beat(32'h4000_0000, 1'b1);
        s_result("posovf", EXP_POS_OVF, 8'd2, EXP_SAT);
        s_drain("posovf");

        // Negative overflow: -1.0 + -1.0
        s_beat(32'h8000_0000, 1'b0);
        s_beat(32'h8000_0000, 1'b1);
        s_result("negovf", EXP_NEG_OVF, 8'd2, EXP_SAT);
        s_drain("negovf");

        // Single negative beat, then backpressure with the next beat held upstream
        s_beat(32'hC000_0000, 1'b1);
        s_result("neg1", 32'hC000_0000, 8'd1, 1'b0);
        s_in_valid = 1'b1;
        s_in_data  = 32'h1234_5678;
        s_in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            s_result("bp_hold", 32'hC000_0000, 8'd1, 1'b0);
        end
        s_out_ready = 1'b1;
        tick();
        s_out_ready = 1'b0;
        chk("bp_valid_drop", 32'(s_out_valid), 32'd0);
        chk("bp_ready_back", 32'(s_in_ready), 32'd1);
        tick();
        s_in_valid = 1'b0;
        s_in_last  = 1'b0;
        s_result("bp_next", 32'h1234_5678, 8'd1, 1'b0);
        s_drain("bp_next");

        // Long group: count saturates and guard bits wrap
        for (int i = 0; i < 299; i++) begin
            s_beat(32'h7FFF_FFFF, 1'b0);
        end
        s_beat(32'h7FFF_FFFF, 1'b1);
        s_result("guard", EXP_GUARD, 8'd255, EXP_SAT);
        s_drain("guard");

        // Reset mid-group discards the partial sum
        s_beat(32'h0000_0100, 1'b0);
        s_beat(32'h0000_0100, 1'b0);
        s_beat(32'h0000_0100, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_ready", 32'(s_in_ready), 32'd1);
        chk("midrst_valid", 32'(s_out_valid), 32'd0);
        chk("midrst_data",  s_out_data, 32'd0);
        s_beat(32'h0000_0010, 1'b1);
        s_result("midrst", 32'h0000_0010, 8'd1, 1'b0);
        s_drain("midrst");

        // Unsigned instance: in-range sum and overflow
        u_beat(32'h8000_0000, 1'b0);
        u_beat(32'h7FFF_FFFF, 1'b1);
        u_result("ufit", 32'hFFFF_FFFF, 8'd2, 1'b0);
        u_drain("ufit");
        u_beat(32'hFFFF_FFFF, 1'b0);
        u_beat(32'h0000_0002, 1'b1);
        u_result("uovf", EXP_U_OVF, 8'd2, EXP_SAT);
        u_drain("uovf");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
